// File: rtl/ps2_pkg.sv
// Shared types and helpers for the PS/2 device-to-host receiver.
package ps2_pkg;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} ps2_state_e;

  localparam logic [7:0] PS2_BREAK = 8'hF0;

  // Odd parity: data bits plus parity bit must contain an odd number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Input synchroniser with optional deglitch; GLITCH_CYCLES=0 gives a bare synchroniser.
module ps2_line_filter #(
  parameter int SYNC_STAGES   = 2,
  parameter int GLITCH_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  // Preset high: an idle PS/2 line is pulled up.
  logic [SYNC_STAGES-1:0] sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync <= '1;
    else     sync <= {sync[SYNC_STAGES-2:0], din};
  end

  generate
    if (GLITCH_CYCLES == 0) begin : g_nofilt
      assign dout = sync[SYNC_STAGES-1];
    end else begin : g_filt
      localparam int CW = $clog2(GLITCH_CYCLES + 1);
      logic [CW-1:0] cnt;
      logic          filt;

      // Any sample matching the current level restarts the run count.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          cnt  <= '0;
          filt <= 1'b1;
        end else if (sync[SYNC_STAGES-1] == filt) begin
          cnt <= '0;
        end else if (cnt == CW'(GLITCH_CYCLES - 1)) begin
          filt <= sync[SYNC_STAGES-1];
          cnt  <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end

      assign dout = filt;
    end
  endgenerate

endmodule

// File: rtl/ps2_frame_rx.sv
// PS/2 device-to-host frame receiver: sync, deglitch, deframe, parity/stop/timeout checks.
// Define PS2_BREAK_FILTER_EN to fold the F0 break prefix into an rx_release strobe.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int GLITCH_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2clk,
  input  logic       key_data,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_release,
  output logic       rx_err,
  output logic       busy
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES);

  logic clk_f, clk_f_d, fall, dat_s;

  ps2_line_filter #(.SYNC_STAGES(SYNC_STAGES), .GLITCH_CYCLES(GLITCH_CYCLES)) u_clk_filt (
    .clk(clk), .rst(rst), .din(ps2clk), .dout(clk_f)
  );

  ps2_line_filter #(.SYNC_STAGES(SYNC_STAGES), .GLITCH_CYCLES(0)) u_dat_sync (
    .clk(clk), .rst(rst), .din(key_data), .dout(dat_s)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_f_d <= 1'b1;
      fall    <= 1'b0;
    end else begin
      clk_f_d <= clk_f;
      fall    <= clk_f_d & ~clk_f;
    end
  end

  ps2_state_e    state, state_n;
  logic [2:0]    bit_cnt, bit_cnt_n;
  logic [7:0]    shreg, shreg_n;
  logic          par_q, par_n;
  logic [TW-1:0] tmo_cnt, tmo_n;
  logic [7:0]    data_n;
  logic          valid_n, err_n;
`ifdef PS2_BREAK_FILTER_EN
  logic          rel_q, rel_n, flag, flag_n;
`endif

  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    shreg_n   = shreg;
    par_n     = par_q;
    data_n    = rx_data;
    valid_n   = 1'b0;
    err_n     = 1'b0;
`ifdef PS2_BREAK_FILTER_EN
    rel_n     = 1'b0;
    flag_n    = flag;
`endif
    if (state == IDLE || fall) tmo_n = '0;
    else if (tmo_cnt == TMO_MAX) tmo_n = tmo_cnt;
    else tmo_n = tmo_cnt + TW'(1);

    // A fall on the terminal-count cycle takes priority over the timeout.
    if (fall) begin
      unique case (state)
        IDLE: if (!dat_s) begin
          state_n   = DATA;
          bit_cnt_n = '0;
        end
        DATA: begin
          shreg_n   = {dat_s, shreg[7:1]};
          bit_cnt_n = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_n = PARITY;
        end
        PARITY: begin
          par_n   = dat_s;
          state_n = STOP;
        end
        STOP: begin
          state_n = IDLE;
          if (odd_parity_ok(shreg, par_q) && dat_s) begin
`ifdef PS2_BREAK_FILTER_EN
            if (flag) begin
              data_n = shreg;
              rel_n  = 1'b1;
              flag_n = 1'b0;
            end else if (shreg == PS2_BREAK) begin
              flag_n = 1'b1;
            end else begin
              data_n  = shreg;
              valid_n = 1'b1;
            end
`else
            data_n  = shreg;
            valid_n = 1'b1;
`endif
          end else begin
            err_n = 1'b1;
`ifdef PS2_BREAK_FILTER_EN
            flag_n = 1'b0;
`endif
          end
        end
        default: state_n = IDLE;
      endcase
    end else if (state != IDLE && tmo_cnt == TMO_MAX) begin
      state_n   = IDLE;
      bit_cnt_n = '0;
      err_n     = 1'b1;
`ifdef PS2_BREAK_FILTER_EN
      flag_n    = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      shreg    <= '0;
      par_q    <= 1'b0;
      tmo_cnt  <= '0;
      rx_data  <= 8'h00;
      rx_valid <= 1'b0;
      rx_err   <= 1'b0;
    end else begin
      state    <= state_n;
      bit_cnt  <= bit_cnt_n;
      shreg    <= shreg_n;
      par_q    <= par_n;
      tmo_cnt  <= tmo_n;
      rx_data  <= data_n;
      rx_valid <= valid_n;
      rx_err   <= err_n;
    end
  end

`ifdef PS2_BREAK_FILTER_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rel_q <= 1'b0;
      flag  <= 1'b0;
    end else begin
      rel_q <= rel_n;
      flag  <= flag_n;
    end
  end
  assign rx_release = rel_q;
`else
  assign rx_release = 1'b0;
`endif

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_ps2_frame_rx.sv
// Directed bench for ps2_frame_rx with a shortened PS/2 clock and timeout.
module tb_ps2_frame_rx;

  localparam int SYNC = 2;
  localparam int GLT  = 4;
  localparam int TMO  = 200;
  localparam int H    = 20;   // clk cycles per ps2clk half period
  localparam int LAT  = SYNC + GLT + 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2clk = 1'b1;
  logic       key_data = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid, rx_release, rx_err, busy;

  int checks = 0;
  int errors = 0;
  int nvalid = 0, nerr = 0, nrel = 0;
  int lat;

  ps2_frame_rx #(.SYNC_STAGES(SYNC), .GLITCH_CYCLES(GLT), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .ps2clk(ps2clk), .key_data(key_data),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_release(rx_release),
    .rx_err(rx_err), .busy(busy)
  );

  always #5 clk = ~clk;

  // Strobe counters and the one-hot strobe rule.
  always @(negedge clk) begin
    if (rx_valid)   nvalid++;
    if (rx_err)     nerr++;
    if (rx_release) nrel++;
    if (rx_valid || rx_err || rx_release) begin
      checks++;
      if (int'(rx_valid) + int'(rx_err) + int'(rx_release) > 1) begin
        errors++;
        $display("FAIL strobe_exclusive: valid=%0b err=%0b release=%0b expected at most one", rx_valid, rx_err, rx_release);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [10:0] mk(input logic [7:0] d, input logic p, input logic s);
    return {s, p, d, 1'b0};
  endfunction

  // Data changes mid-high; lat records cycles from raw fall to rx_valid.
  task automatic send_bit(input logic b);
    wait_clks(H/2);
    key_data = b;
    wait_clks(H/2);
    ps2clk = 1'b0;
    lat = -1;
    for (int k = 1; k <= H; k++) begin
      @(negedge clk);
      if (rx_valid && lat < 0) lat = k;
    end
    ps2clk = 1'b1;
  endtask

  task automatic send_bits(input logic [10:0] f, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) send_bit(f[i]);
  endtask

  task automatic send_frame(input logic [7:0] d);
    send_bits(mk(d, ~^d, 1'b1), 0, 10);
    key_data = 1'b1;
    wait_clks(3*H);
  endtask

  task automatic test_reset;
    wait_clks(3);
    checks++;
    if (rx_data !== 8'h00 || rx_valid !== 1'b0 || rx_err !== 1'b0 || rx_release !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: data=%h v=%b e=%b r=%b busy=%b expected all zero", rx_data, rx_valid, rx_err, rx_release, busy);
    end
    rst = 1'b0;
    wait_clks(5);
  endtask

  task automatic test_good_frame;
    int v0, e0;
    v0 = nvalid; e0 = nerr;
    send_bits(mk(8'h1C, 1'b0, 1'b1), 0, 10);
    checks++;
    if (lat !== LAT) begin errors++; $display("FAIL latency: got %0d expected %0d", lat, LAT); end
    key_data = 1'b1;
    wait_clks(3*H);
    checks++;
    if (nvalid - v0 !== 1) begin errors++; $display("FAIL good_valid_count: got %0d expected 1", nvalid - v0); end
    checks++;
    if (rx_data !== 8'h1C) begin errors++; $display("FAIL good_data: got %h expected 1c", rx_data); end
    checks++;
    if (nerr - e0 !== 0 || busy !== 1'b0) begin errors++; $display("FAIL good_err_busy: err=%0d busy=%b expected 0 0", nerr - e0, busy); end
  endtask

  task automatic test_bad_frames;
    int v0, e0;
    v0 = nvalid; e0 = nerr;
    send_bits(mk(8'h1C, 1'b1, 1'b1), 0, 10);
    key_data = 1'b1; wait_clks(3*H);
    checks++;
    if (nerr - e0 !== 1) begin errors++; $display("FAIL parity_err: got %0d expected 1", nerr - e0); end
    send_bits(mk(8'h1C, 1'b0, 1'b0), 0, 10);
    key_data = 1'b1; wait_clks(3*H);
    checks++;
    if (nerr - e0 !== 2) begin errors++; $display("FAIL stop_err: got %0d expected 2", nerr - e0); end
    checks++;
    if (nvalid - v0 !== 0 || rx_data !== 8'h1C) begin
      errors++; $display("FAIL bad_no_valid: valid=%0d data=%h expected 0 1c", nvalid - v0, rx_data);
    end
  endtask

  task automatic test_timeout;
    int v0, e0;
    v0 = nvalid; e0 = nerr;
    send_bits(mk(8'h29, 1'b0, 1'b1), 0, 5);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL partial_busy: got %b expected 1", busy); end
    wait_clks(TMO + 10 + LAT);
    checks++;
    if (nerr - e0 !== 1 || busy !== 1'b0) begin
      errors++; $display("FAIL timeout_err: err=%0d busy=%b expected 1 0", nerr - e0, busy);
    end
    send_frame(8'h29);
    checks++;
    if (nvalid - v0 !== 1 || rx_data !== 8'h29) begin
      errors++; $display("FAIL after_timeout: valid=%0d data=%h expected 1 29", nvalid - v0, rx_data);
    end
  endtask

  task automatic test_glitch;
    int v0, e0;
    logic [10:0] f;
    v0 = nvalid; e0 = nerr;
    f = mk(8'h75, 1'b0, 1'b1);
    key_data = 1'b0;
    wait_clks(5);
    ps2clk = 1'b0; wait_clks(2); ps2clk = 1'b1;
    wait_clks(20);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL idle_glitch: busy=%b expected 0", busy); end
    key_data = 1'b1;
    wait_clks(H);
    send_bits(f, 0, 3);
    wait_clks(5);
    ps2clk = 1'b0; wait_clks(2); ps2clk = 1'b1;
    send_bits(f, 4, 10);
    key_data = 1'b1; wait_clks(3*H);
    checks++;
    if (nvalid - v0 !== 1 || rx_data !== 8'h75 || nerr - e0 !== 0) begin
      errors++; $display("FAIL mid_glitch: valid=%0d data=%h err=%0d expected 1 75 0", nvalid - v0, rx_data, nerr - e0);
    end
  endtask

  task automatic test_break;
    int v0, r0;
    v0 = nvalid; r0 = nrel;
    send_frame(8'hF0);
    checks++;
`ifdef PS2_BREAK_FILTER_EN
    if (rx_data !== 8'h75 || nvalid - v0 !== 0) begin
      errors++; $display("FAIL break_f0: data=%h valid=%0d expected 75 0", rx_data, nvalid - v0);
    end
`else
    if (rx_data !== 8'hF0 || nvalid - v0 !== 1) begin
      errors++; $display("FAIL break_f0: data=%h valid=%0d expected f0 1", rx_data, nvalid - v0);
    end
`endif
    send_frame(8'h1C);
    checks++;
`ifdef PS2_BREAK_FILTER_EN
    if (rx_data !== 8'h1C || nvalid - v0 !== 0 || nrel - r0 !== 1) begin
      errors++; $display("FAIL break_1c: data=%h valid=%0d rel=%0d expected 1c 0 1", rx_data, nvalid - v0, nrel - r0);
    end
`else
    if (rx_data !== 8'h1C || nvalid - v0 !== 2 || nrel - r0 !== 0) begin
      errors++; $display("FAIL break_1c: data=%h valid=%0d rel=%0d expected 1c 2 0", rx_data, nvalid - v0, nrel - r0);
    end
`endif
  endtask

  task automatic test_reset_midframe;
    int v0, e0;
    v0 = nvalid; e0 = nerr;
    send_bits(mk(8'h5A, 1'b1, 1'b1), 0, 4);
    rst = 1'b1;
    wait_clks(2);
    checks++;
    if (rx_data !== 8'h00 || busy !== 1'b0 || rx_valid !== 1'b0 || rx_err !== 1'b0 || rx_release !== 1'b0) begin
      errors++; $display("FAIL midframe_reset: data=%h busy=%b v=%b e=%b r=%b expected all zero", rx_data, busy, rx_valid, rx_err, rx_release);
    end
    rst = 1'b0;
    key_data = 1'b1;
    wait_clks(TMO + 50);
    checks++;
    if (nerr - e0 !== 0) begin errors++; $display("FAIL reset_no_err: got %0d expected 0", nerr - e0); end
    send_frame(8'h5A);
    checks++;
    if (nvalid - v0 !== 1 || rx_data !== 8'h5A) begin
      errors++; $display("FAIL after_reset: valid=%0d data=%h expected 1 5a", nvalid - v0, rx_data);
    end
  endtask

  initial begin
    test_reset;
    test_good_frame;
    test_bad_frames;
    test_timeout;
    test_glitch;
    test_break;
    test_reset_midframe;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
